// File: rtl/booth_dot_product_accumulator.sv
// booth_dot_product_accumulator
// Sums a programmed number of signed products (one per prod_valid strobe)
// into a wide signed accumulator. The final sum is reported with a one-cycle
// acc_valid pulse. A sticky overflow flag records any add that left the
// ACC_W range. SATURATE selects clamping or two's-complement wrap.
module booth_dot_product_accumulator #(
  parameter int WIDTH    = 8,
  parameter int ACC_W    = 2*WIDTH+4,
  parameter int LEN_W    = 5,
  parameter bit SATURATE = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LEN_W-1:0]   vec_len,
  input  logic               prod_valid,
  input  logic [2*WIDTH-1:0] prod_in,
  output logic [ACC_W-1:0]   acc_out,
  output logic               acc_valid,
  output logic               busy,
  output logic               overflow
);

  localparam int PW  = 2*WIDTH;
  // The sum is formed one bit wider than the accumulator; EXT is the number
  // of sign bits needed to bring the product up to that width.
  localparam int EXT = ACC_W + 1 - PW;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   acc_out_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   count_q;
  logic               acc_valid_q;
  logic               busy_q;
  logic               overflow_q;

  logic [ACC_W:0]     sum_s;
  logic               add_ovf_s;
  logic [ACC_W-1:0]   acc_d;
  logic               last_s;

  // Widen both operands by sign extension so the add can never lose its sign.
  function automatic logic [ACC_W:0] sext_acc(input logic [ACC_W-1:0] a);
    return {a[ACC_W-1], a};
  endfunction

  function automatic logic [ACC_W:0] sext_prod(input logic [PW-1:0] p);
    return {{EXT{p[PW-1]}}, p};
  endfunction

  // Next accumulator value: wide sum, overflow detect, then clamp or wrap.
  always_comb begin
    sum_s     = sext_acc(acc_q) + sext_prod(prod_in);
    add_ovf_s = sum_s[ACC_W] ^ sum_s[ACC_W-1];
    if (add_ovf_s && (SATURATE != 1'b0)) begin
      acc_d = sum_s[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_d = sum_s[ACC_W-1:0];
    end
    last_s = (count_q == (len_q - LEN_W'(1)));
  end

  // Control FSM with registered outputs; result and flag hold until next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      acc_out_q   <= '0;
      len_q       <= '0;
      count_q     <= '0;
      acc_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          acc_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          if (start) begin
            len_q      <= vec_len;
            acc_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b1;
            if (vec_len != '0) begin
              state_q <= S_ACCUM;
            end else begin
              // Empty vector: report a zero sum straight away.
              state_q     <= S_DONE;
              acc_out_q   <= '0;
              acc_valid_q <= 1'b1;
            end
          end
        end
        S_ACCUM: begin
          if (prod_valid) begin
            acc_q   <= acc_d;
            count_q <= count_q + LEN_W'(1);
            if (add_ovf_s) begin
              overflow_q <= 1'b1;
            end
            if (last_s) begin
              acc_out_q   <= acc_d;
              acc_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_DONE: begin
          acc_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: begin
          acc_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign acc_out   = acc_out_q;
  assign acc_valid = acc_valid_q;
  assign busy      = busy_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_booth_dot_product_accumulator.sv
// Testbench for booth_dot_product_accumulator. Three instances share stimulus:
// the default 20-bit saturating accumulator, a 16-bit saturating one and a
// 16-bit wrapping one. Expected sums come from an integer reference model.
module tb_booth_dot_product_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  vec_len = '0;
  logic        prod_valid = 1'b0;
  logic [15:0] prod_in = '0;

  logic [19:0] acc20;
  logic [15:0] acc16s, acc16w;
  logic        av20, av16s, av16w;
  logic        bz20, bz16s, bz16w;
  logic        ov20, ov16s, ov16w;

  int total = 0;
  int bad   = 0;
  int pc20  = 0;
  int pc16s = 0;
  int pc16w = 0;

  longint prods[$];

  booth_dot_product_accumulator #(.WIDTH(8), .ACC_W(20), .LEN_W(5), .SATURATE(1'b1)) dut20 (
    .clk(clk), .rst(rst), .start(start), .vec_len(vec_len), .prod_valid(prod_valid),
    .prod_in(prod_in), .acc_out(acc20), .acc_valid(av20), .busy(bz20), .overflow(ov20));

  booth_dot_product_accumulator #(.WIDTH(8), .ACC_W(16), .LEN_W(5), .SATURATE(1'b1)) dut16s (
    .clk(clk), .rst(rst), .start(start), .vec_len(vec_len), .prod_valid(prod_valid),
    .prod_in(prod_in), .acc_out(acc16s), .acc_valid(av16s), .busy(bz16s), .overflow(ov16s));

  booth_dot_product_accumulator #(.WIDTH(8), .ACC_W(16), .LEN_W(5), .SATURATE(1'b0)) dut16w (
    .clk(clk), .rst(rst), .start(start), .vec_len(vec_len), .prod_valid(prod_valid),
    .prod_in(prod_in), .acc_out(acc16w), .acc_valid(av16w), .busy(bz16w), .overflow(ov16w));

  always #5 clk = ~clk;

  // Count acc_valid pulses per instance.
  always @(posedge clk) begin
    if (av20)  pc20  <= pc20 + 1;
    if (av16s) pc16s <= pc16s + 1;
    if (av16w) pc16w <= pc16w + 1;
  end

  // Reference: running integer sum, clamped or wrapped into w bits on overflow.
  function automatic void model(input int w, input bit sat, output longint sum, output bit ovf);
    longint mx;
    longint mn;
    longint m;
    mx  = (longint'(1) << (w - 1)) - 1;
    mn  = -mx - 1;
    m   = longint'(1) << w;
    sum = 0;
    ovf = 1'b0;
    foreach (prods[k]) begin
      sum = sum + prods[k];
      if (sum > mx || sum < mn) begin
        ovf = 1'b1;
        if (sat) begin
          sum = (sum > mx) ? mx : mn;
        end else begin
          sum = sum % m;
          if (sum < 0) sum = sum + m;
          if (sum > mx) sum = sum - m;
        end
      end
    end
  endfunction

  // Run one vector from the prods queue and check all three instances.
  // noise: stray prod_valid in IDLE/DONE and stray start during ACCUM/DONE.
  task automatic run_vec(input string name, input int gap_max, input bit noise);
    longint e20, e16s, e16w;
    bit     o20, o16s, o16w;
    int     p0_20, p0_16s, p0_16w, g, len;
    len = prods.size();
    model(20, 1'b1, e20, o20);
    model(16, 1'b1, e16s, o16s);
    model(16, 1'b0, e16w, o16w);
    if (noise) begin
      prod_valid = 1'b1; prod_in = 16'h1234;
      @(posedge clk); #1;
      prod_valid = 1'b0;
    end
    p0_20 = pc20; p0_16s = pc16s; p0_16w = pc16w;
    start = 1'b1; vec_len = 5'(len);
    @(posedge clk); #1;
    start = 1'b0;
    if (len != 0) begin
      total++;
      if ({bz20, bz16s, bz16w, av20, av16s, av16w} !== 6'b111000) begin
        bad++;
        $display("FAIL %s busy/valid after start: got %b want 111000", name,
                 {bz20, bz16s, bz16w, av20, av16s, av16w});
      end
    end
    for (int k = 0; k < len; k++) begin
      g = $urandom_range(gap_max, noise ? 1 : 0);
      repeat (g) begin
        if (noise) begin start = 1'b1; vec_len = 5'd1; end
        @(posedge clk); #1;
        start = 1'b0;
      end
      prod_valid = 1'b1; prod_in = 16'(prods[k]);
      @(posedge clk); #1;
      prod_valid = 1'b0;
    end
    // Result cycle (DONE)
    total++;
    if ({av20, av16s, av16w, bz20, bz16s, bz16w} !== 6'b111111) begin
      bad++;
      $display("FAIL %s valid/busy at result: got %b want 111111", name,
               {av20, av16s, av16w, bz20, bz16s, bz16w});
    end
    total++;
    if (acc20 !== 20'(e20)) begin
      bad++; $display("FAIL %s acc20: got %0d want %0d", name, $signed(acc20), e20);
    end
    total++;
    if (acc16s !== 16'(e16s)) begin
      bad++; $display("FAIL %s acc16s: got %0d want %0d", name, $signed(acc16s), e16s);
    end
    total++;
    if (acc16w !== 16'(e16w)) begin
      bad++; $display("FAIL %s acc16w: got %0d want %0d", name, $signed(acc16w), e16w);
    end
    total++;
    if ({ov20, ov16s, ov16w} !== {o20, o16s, o16w}) begin
      bad++; $display("FAIL %s overflow: got %b want %b", name, {ov20, ov16s, ov16w}, {o20, o16s, o16w});
    end
    if (noise) begin
      prod_valid = 1'b1; prod_in = 16'h0777; start = 1'b1; vec_len = 5'd3;
    end
    @(posedge clk); #1;
    prod_valid = 1'b0; start = 1'b0;
    // Back in IDLE: pulse gone, busy low, result and flag held
    total++;
    if ({av20, av16s, av16w, bz20, bz16s, bz16w} !== 6'b000000) begin
      bad++;
      $display("FAIL %s valid/busy after result: got %b want 000000", name,
               {av20, av16s, av16w, bz20, bz16s, bz16w});
    end
    total++;
    if (acc20 !== 20'(e20) || acc16s !== 16'(e16s) || acc16w !== 16'(e16w) ||
        {ov20, ov16s, ov16w} !== {o20, o16s, o16w}) begin
      bad++; $display("FAIL %s hold: got %0d/%0d/%0d ov=%b want %0d/%0d/%0d ov=%b", name,
                      $signed(acc20), $signed(acc16s), $signed(acc16w), {ov20, ov16s, ov16w},
                      e20, e16s, e16w, {o20, o16s, o16w});
    end
    total++;
    if ((pc20 - p0_20) != 1 || (pc16s - p0_16s) != 1 || (pc16w - p0_16w) != 1) begin
      bad++; $display("FAIL %s pulse count: got %0d/%0d/%0d want 1/1/1", name,
                      pc20 - p0_20, pc16s - p0_16s, pc16w - p0_16w);
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({av20, av16s, av16w, bz20, bz16s, bz16w, ov20, ov16s, ov16w} !== 9'b0 ||
        acc20 !== 20'd0 || acc16s !== 16'd0 || acc16w !== 16'd0) begin
      bad++; $display("FAIL reset outputs: got acc=%h/%h/%h flags=%b want all 0", acc20, acc16s, acc16w,
                      {av20, av16s, av16w, bz20, bz16s, bz16w, ov20, ov16s, ov16w});
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    prods = '{100, -50, 7};
    run_vec("basic", 5, 1'b0);
    total++;
    if (acc20 !== 20'd57 || ov20 !== 1'b0) begin
      bad++; $display("FAIL basic_const: got %0d ov=%b want 57 ov=0", $signed(acc20), ov20);
    end
  endtask

  task automatic test_zero_len();
    prods.delete();
    run_vec("zero_len", 0, 1'b0);
  endtask

  task automatic test_saturate();
    prods = '{16384, 16384, 16384};
    run_vec("sat3", 2, 1'b0);
    total++;
    if (acc16s !== 16'sd32767 || acc16w !== 16'hC000 || ov16s !== 1'b1 || ov16w !== 1'b1) begin
      bad++; $display("FAIL sat_const: got %0d/%0d ov=%b%b want 32767/-16384 ov=11",
                      $signed(acc16s), $signed(acc16w), ov16s, ov16w);
    end
    prods = '{-5};
    run_vec("after_sat", 1, 1'b0);
    total++;
    if (acc16s !== 16'hFFFB || ov16s !== 1'b0) begin
      bad++; $display("FAIL after_sat_const: got %0d ov=%b want -5 ov=0", $signed(acc16s), ov16s);
    end
  endtask

  task automatic test_ignore();
    prods = '{3, 4};
    run_vec("ignore", 3, 1'b1);
    total++;
    if (acc20 !== 20'd7) begin
      bad++; $display("FAIL ignore_const: got %0d want 7", $signed(acc20));
    end
  endtask

  task automatic test_mid_reset();
    int p0;
    p0 = pc20 + pc16s + pc16w;
    start = 1'b1; vec_len = 5'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin
      prod_valid = 1'b1; prod_in = 16'd16384;
      @(posedge clk); #1;
    end
    prod_valid = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if ({av20, av16s, av16w, bz20, bz16s, bz16w, ov20, ov16s, ov16w} !== 9'b0 ||
        acc20 !== 20'd0 || acc16s !== 16'd0 || acc16w !== 16'd0) begin
      bad++; $display("FAIL mid_reset outputs: got acc=%h/%h/%h flags=%b want all 0", acc20, acc16s, acc16w,
                      {av20, av16s, av16w, bz20, bz16s, bz16w, ov20, ov16s, ov16w});
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if ((pc20 + pc16s + pc16w) != p0) begin
      bad++; $display("FAIL mid_reset pulses: got %0d want 0", pc20 + pc16s + pc16w - p0);
    end
    prods = '{9};
    run_vec("after_reset", 1, 1'b0);
  endtask

  task automatic test_random();
    for (int v = 0; v < 14; v++) begin
      int n;
      bit same;
      longint p;
      n    = $urandom_range(31, 1);
      same = 1'($urandom_range(1, 0));
      prods.delete();
      for (int k = 0; k < n; k++) begin
        p = longint'($signed(16'($urandom)));
        if (same) begin
          p = longint'($urandom_range(32767, 20000));
          if (v[1]) p = -p;
        end
        prods.push_back(p);
      end
      run_vec($sformatf("rand%0d", v), 2, v[0]);
    end
  endtask

  task automatic test_back_to_back();
    prods = '{-32768, -32768, 1};
    run_vec("b2b_a", 0, 1'b0);
    prods.delete();
    run_vec("b2b_b", 0, 1'b0);
    prods = '{32767};
    run_vec("b2b_c", 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_saturate();
    test_ignore();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
